mem_responder: RTL and testbench
================================

# mem_responder

Single-port memory responder that serves the CPU controller's memory bus: it accepts `rd`/`wr` strobes, the 5-bit address from the PC/IR address mux and the accumulator data driven under `data_e`, and returns registered read data for instruction fetch (IR load) and operand fetch (AC load). It includes a backdoor program-load port for preloading code while the CPU is held in reset or halted, and optionally a memory-mapped I/O page.

## Interface
- `AWIDTH`, 5, address width (32 words)
- `DWIDTH`, 8, data width (3-bit opcode + 5-bit operand)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `addr`  in  AWIDTH  bus address (controller `sel` already applied upstream)
- `rd`  in  1  read strobe, level
- `wr`  in  1  write strobe, level; may stay high more than one cycle
- `data_in`  in  DWIDTH  write data (accumulator, valid while `data_e`)
- `data_out`  out  DWIDTH  registered read data
- `data_valid`  out  1  `data_out` was updated by a read on the previous edge
- `ld_en`  in  1  backdoor load strobe
- `ld_addr`  in  AWIDTH  backdoor load address
- `ld_data`  in  DWIDTH  backdoor load data
- `err`  out  1  sticky protocol error
- `io_in`  in  DWIDTH  external input byte (only with `MEM_IO_EN`)
- `io_out`  out  DWIDTH  output register (only with `MEM_IO_EN`)
- `io_out_stb`  out  1  one-cycle pulse on `io_out` update (only with `MEM_IO_EN`)

## Operation
- Reset (`rst`=1 at edge): `data_out`=0, `data_valid`=0, `err`=0, `wr_q`=0, `io_out`=0, `io_out_stb`=0. RAM contents are not cleared.
- Write detect: `wr_q` registers `wr`. A bus write commits only on a rising edge of `wr` (`wr`=1, `wr_q`=0); held `wr` performs exactly one write.
- Read: on every edge with `rd`=1 and `wr`=0, `data_out` <= word at `addr`; `data_valid` <= 1. With `rd`=0, `data_out` holds, `data_valid` <= 0.
- `rd`=1 and `wr`=1 together: write proceeds per edge rule, read suppressed (`data_out` holds, `data_valid`=0), `err` <= 1.
- Backdoor load: `ld_en`=1 writes `ld_data` to `ld_addr` when no bus write commits and `rd`=0. If `ld_en` coincides with `rd`=1 or a committing bus write, load is dropped and `err` <= 1. Bus always wins.
- `err` stays set until `rst`.
- Address arithmetic: `addr` used unmodified, no wrap logic; all 2^AWIDTH words valid.

## Timing
- Read latency 1 cycle: `addr`/`rd` sampled at edge N, `data_out` valid after edge N, usable at edge N+1. Controller holds `rd` across FETCH→LOAD so IR loads correct data.
- Write-to-read: write at edge N, read sampled at edge N+1 returns new data (no forwarding needed; no same-edge read/write allowed).
- `io_out_stb` high exactly the cycle after the committing write edge.
- Reset mid-access: pending write on the same edge as `rst`=1 is discarded; `wr_q` cleared, so a `wr` still high after reset counts as a new rising edge.

## Configuration
- `MEM_IO_EN` defined: address `AWIDTH'h1E` reads `io_in` (writes ignored, no RAM update); address `AWIDTH'h1F` write updates `io_out` and pulses `io_out_stb`, read returns `io_out`; RAM words 0x1E/0x1F unreachable from the bus but backdoor loads to them still land in RAM.
- Not defined: `io_in`, `io_out`, `io_out_stb` ports absent; all 32 addresses are RAM.

## Structure
- Shared package `risc_pkg`: `AWIDTH`, `DWIDTH` defaults, `IO_IN_ADDR`=0x1E, `IO_OUT_ADDR`=0x1F, opcode constants (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) for bench use.
- One sub-module `mem_array`: 2^AWIDTH x DWIDTH, one synchronous write port, one synchronous read port; strobe decode, arbitration, error and I/O logic stay in `mem_responder`.

## Test plan
- Backdoor load 0x1F→addr 3, then `rd`=1 addr 3 for 2 cycles -> `data_out`=0x1F one cycle after first `rd`, `data_valid`=1, `err`=0.
- `data_in`=0xA5, `wr` held 3 cycles at addr 7, then read addr 7 -> 0xA5; write counted once (verified via `io_out_stb` single pulse with addr 0x1F under `MEM_IO_EN`).
- `rd`=1 and `wr`=1 same cycle, addr 4, `data_in`=0x3C -> RAM[4]=0x3C, `data_out` unchanged, `err`=1 until `rst`.
- `ld_en`=1 during `rd`=1 at addr 9 -> load dropped, RAM[9] unchanged, `err`=1.
- `MEM_IO_EN`: `io_in`=0x5A, read 0x1E -> 0x5A; write 0x77 to 0x1F -> `io_out`=0x77, one-cycle `io_out_stb`.
- `rst` asserted on the edge of a `wr` rising edge at addr 2 -> RAM[2] unchanged, all outputs at reset values next cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg
// Shared constants for the small RISC CPU and its memory responder:
// bus widths, the memory-mapped I/O addresses and the opcode encoding
// (the opcodes are used by benches and the controller, not by the memory).
package risc_pkg;

  localparam int AWIDTH = 5;
  localparam int DWIDTH = 8;

  localparam int IO_IN_ADDR  = 'h1E;
  localparam int IO_OUT_ADDR = 'h1F;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Plain 2^AWIDTH x DWIDTH storage with one synchronous write port and one
// synchronous read port. The read register holds its value when re is low
// and clears on rst; the storage itself is never cleared.
// Ports:
//   clk, rst          clock, synchronous active-high reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr, rdata  registered read port
import risc_pkg::*;

module mem_array #(
  parameter int AWIDTH = risc_pkg::AWIDTH,
  parameter int DWIDTH = risc_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Single-port memory responder for the CPU memory bus. Bus writes commit on
// the rising edge of wr only; reads are registered with one cycle latency.
// A backdoor load port preloads code whenever the bus is not using the array.
// Optional feature macro: MEM_IO_EN adds an input byte at 0x1E and an output
// register at 0x1F in place of the RAM words at those addresses.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   addr, rd, wr, data_in         bus address, read/write strobes, write data
//   data_out, data_valid          registered read data and its valid flag
//   ld_en, ld_addr, ld_data       backdoor load port
//   err                           sticky protocol error (cleared by rst)
//   io_in, io_out, io_out_stb     I/O page (MEM_IO_EN builds only)
import risc_pkg::*;

module mem_responder #(
  parameter int AWIDTH = risc_pkg::AWIDTH,
  parameter int DWIDTH = risc_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
  output logic              err
`ifdef MEM_IO_EN
  ,
  input  logic [DWIDTH-1:0] io_in,
  output logic [DWIDTH-1:0] io_out,
  output logic              io_out_stb
`endif
);

  logic              wr_q;
  logic              wr_rise;
  logic              rd_ok;
  logic              is_io;
  logic              bus_we;
  logic              ld_ok;
  logic              err_set;
  logic              arr_we;
  logic [AWIDTH-1:0] arr_waddr;
  logic [DWIDTH-1:0] arr_wdata;
  logic              arr_re;
  logic [DWIDTH-1:0] ram_rdata;

`ifdef MEM_IO_EN
  localparam logic [AWIDTH-1:0] IO_IN_A  = AWIDTH'(IO_IN_ADDR);
  localparam logic [AWIDTH-1:0] IO_OUT_A = AWIDTH'(IO_OUT_ADDR);

  logic              is_io_in;
  logic              is_io_out;
  logic              src_io;
  logic [DWIDTH-1:0] io_rd_q;
`endif

  // Strobe decode and arbitration. Reset masks every array write so a
  // write or load landing on the reset edge is discarded. The bus owns the
  // array whenever it reads or commits a write; a load at those times is
  // dropped and flagged.
  always_comb begin
    wr_rise = wr & ~wr_q;
    rd_ok   = rd & ~wr;
`ifdef MEM_IO_EN
    is_io_in  = (addr == IO_IN_A);
    is_io_out = (addr == IO_OUT_A);
    is_io     = is_io_in | is_io_out;
`else
    is_io     = 1'b0;
`endif
    bus_we    = wr_rise & ~is_io & ~rst;
    ld_ok     = ld_en & ~rd & ~wr_rise & ~rst;
    err_set   = (rd & wr) | (ld_en & (rd | wr_rise));
    arr_we    = bus_we | ld_ok;
    arr_waddr = bus_we ? addr : ld_addr;
    arr_wdata = bus_we ? data_in : ld_data;
    arr_re    = rd_ok & ~is_io;
  end

  mem_array #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (arr_re),
    .raddr(addr),
    .rdata(ram_rdata)
  );

  // Edge-detect register, read-valid flag and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_q       <= wr;
      data_valid <= rd_ok;
      if (err_set) err <= 1'b1;
    end
  end

`ifdef MEM_IO_EN
  // I/O page. src_io remembers whether the last accepted read came from
  // the I/O page so data_out keeps showing that value while rd is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out     <= '0;
      io_out_stb <= 1'b0;
      src_io     <= 1'b0;
      io_rd_q    <= '0;
    end else begin
      io_out_stb <= wr_rise & is_io_out;
      if (wr_rise & is_io_out) io_out <= data_in;
      if (rd_ok) begin
        src_io <= is_io;
        if (is_io) io_rd_q <= is_io_in ? io_in : io_out;
      end
    end
  end

  assign data_out = src_io ? io_rd_q : ram_rdata;
`else
  assign data_out = ram_rdata;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder. Each read pushes its hand-computed
// expected word into a queue; a monitor on the falling edge pops and
// compares whenever data_valid is high. Direct checks cover err, reset
// values and the I/O page (when built with MEM_IO_EN).
import risc_pkg::*;

module tb_mem_responder;

  logic              clk = 1'b0;
  logic              rst;
  logic [AWIDTH-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
  logic              ld_en;
  logic [AWIDTH-1:0] ld_addr;
  logic [DWIDTH-1:0] ld_data;
  logic              err;
`ifdef MEM_IO_EN
  logic [DWIDTH-1:0] io_in;
  logic [DWIDTH-1:0] io_out;
  logic              io_out_stb;
  int                stb_count = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [DWIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .err       (err)
`ifdef MEM_IO_EN
    ,
    .io_in     (io_in),
    .io_out    (io_out),
    .io_out_stb(io_out_stb)
`endif
  );

  task automatic checkOutput(input string name, input logic [DWIDTH-1:0] actual,
                             input logic [DWIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of bus/backdoor inputs, then step past the next edge.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d,
                               input logic le, input logic [AWIDTH-1:0] la,
                               input logic [DWIDTH-1:0] ldd, input logic rs);
    rd = r; wr = w; addr = a; data_in = d;
    ld_en = le; ld_addr = la; ld_data = ldd; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0);
  endtask

  task automatic busRead(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] expected);
    exp_q.push_back(expected);
    applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0);
  endtask

  task automatic load(input logic [AWIDTH-1:0] la, input logic [DWIDTH-1:0] ldd);
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, la, ldd, 1'b0);
  endtask

  // Monitor: every valid read result must match the oldest expectation.
  initial begin
    logic [DWIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: data_out=%h with no read pending", data_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("read_data", data_out, e);
        end
      end
    end
  end

`ifdef MEM_IO_EN
  initial begin
    forever begin
      @(negedge clk);
      if (io_out_stb === 1'b1) stb_count++;
    end
  end
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef MEM_IO_EN
    io_in = 8'h5A;
`endif
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b1);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_data_valid", {7'b0, data_valid}, 8'h00);
    checkOutput("reset_err", {7'b0, err}, 8'h00);

    // Backdoor load then a two-cycle read.
    load(5'h03, 8'h1F);
    busRead(5'h03, 8'h1F);
    checkOutput("read_valid", {7'b0, data_valid}, 8'h01);
    busRead(5'h03, 8'h1F);
    idle();
    checkOutput("valid_drops", {7'b0, data_valid}, 8'h00);
    checkOutput("err_after_load_read", {7'b0, err}, 8'h00);

    // Held wr writes once; data changes during the hold must not land.
    // A load during a held (non-committing) write is allowed.
    applyStimulus(1'b0, 1'b1, 5'h07, 8'hA5, 1'b0, 5'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'h07, 8'h11, 1'b1, 5'h0C, 8'h77, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'h07, 8'h22, 1'b1, 5'h0C, 8'h77, 1'b0);
    idle();
    busRead(5'h07, 8'hA5);
    busRead(5'h0C, 8'h77);
    idle();
    checkOutput("err_after_held_write", {7'b0, err}, 8'h00);

`ifdef MEM_IO_EN
    busRead(5'h1E, 8'h5A);
    load(5'h1E, 8'h12);
    busRead(5'h1E, 8'h5A);
    idle();
    stb_count = 0;
    applyStimulus(1'b0, 1'b1, 5'h1F, 8'h77, 1'b0, 5'h00, 8'h00, 1'b0);
    checkOutput("io_stb_pulse", {7'b0, io_out_stb}, 8'h01);
    checkOutput("io_out_written", io_out, 8'h77);
    applyStimulus(1'b0, 1'b1, 5'h1F, 8'h88, 1'b0, 5'h00, 8'h00, 1'b0);
    checkOutput("io_stb_low", {7'b0, io_out_stb}, 8'h00);
    checkOutput("io_out_held", io_out, 8'h77);
    applyStimulus(1'b0, 1'b1, 5'h1F, 8'h99, 1'b0, 5'h00, 8'h00, 1'b0);
    idle();
    checkOutput("io_stb_count", 8'(stb_count), 8'h01);
    busRead(5'h1F, 8'h77);
    idle();
`else
    applyStimulus(1'b0, 1'b1, 5'h1F, 8'h6C, 1'b0, 5'h00, 8'h00, 1'b0);
    idle();
    busRead(5'h1F, 8'h6C);
    idle();
`endif

    // rd and wr together: write lands, read suppressed, err sticks.
    load(5'h04, 8'h00);
    busRead(5'h07, 8'hA5);
    applyStimulus(1'b1, 1'b1, 5'h04, 8'h3C, 1'b0, 5'h00, 8'h00, 1'b0);
    checkOutput("rdwr_data_hold", data_out, 8'hA5);
    checkOutput("rdwr_valid", {7'b0, data_valid}, 8'h00);
    checkOutput("rdwr_err", {7'b0, err}, 8'h01);
    idle();
    busRead(5'h04, 8'h3C);
    checkOutput("err_sticky", {7'b0, err}, 8'h01);
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b1);
    checkOutput("err_cleared", {7'b0, err}, 8'h00);

    // Load colliding with a read is dropped.
    load(5'h09, 8'h42);
    exp_q.push_back(8'h42);
    applyStimulus(1'b1, 1'b0, 5'h09, 8'h00, 1'b1, 5'h09, 8'h99, 1'b0);
    checkOutput("ld_rd_err", {7'b0, err}, 8'h01);
    busRead(5'h09, 8'h42);
    idle();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b1);

    // Load colliding with a committing bus write is dropped; bus write lands.
    load(5'h0B, 8'h66);
    applyStimulus(1'b0, 1'b1, 5'h0A, 8'h10, 1'b1, 5'h0B, 8'h55, 1'b0);
    checkOutput("ld_wr_err", {7'b0, err}, 8'h01);
    idle();
    busRead(5'h0B, 8'h66);
    busRead(5'h0A, 8'h10);
    idle();

    // Reset on a write's rising edge discards the write.
    load(5'h02, 8'h2B);
    idle();
    applyStimulus(1'b0, 1'b1, 5'h02, 8'hEE, 1'b0, 5'h00, 8'h00, 1'b1);
    checkOutput("rstwr_data_out", data_out, 8'h00);
    checkOutput("rstwr_valid", {7'b0, data_valid}, 8'h00);
    checkOutput("rstwr_err", {7'b0, err}, 8'h00);
`ifdef MEM_IO_EN
    checkOutput("rstwr_io_out", io_out, 8'h00);
`endif
    idle();
    busRead(5'h02, 8'h2B);
    idle();

    // wr held through reset counts as a fresh rising edge afterwards.
    applyStimulus(1'b0, 1'b1, 5'h0D, 8'h31, 1'b0, 5'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'h0D, 8'h31, 1'b0, 5'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'h0D, 8'h32, 1'b0, 5'h00, 8'h00, 1'b0);
    idle();
    busRead(5'h0D, 8'h32);
    idle();
    idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_reads: %0d reads never returned, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
